// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver with a first-word-fall-through
// output FIFO. Runs on clk100 with a fixed bit period of BIT_CYCLES clocks.
//
// Ports:
//   clk100     in   system clock
//   reset      in   asynchronous, active-high reset
//   rx         in   serial line, asynchronous, idle high
//   rx_data    out  FIFO head word (DATA_BITS)
//   rx_perr    out  parity error flag stored with the head word
//   rx_valid   out  FIFO not empty
//   rx_ready   in   consumer accepts head when rx_valid && rx_ready
//   frame_err  out  one-cycle pulse, stop bit sampled low
//   overrun    out  one-cycle pulse, good frame dropped on a full FIFO
//   busy       out  receiver FSM not idle
//
// Build option: define UART_RX_MAJORITY_EN to take each bit as the majority
// of three consecutive samples around the bit centre (adds one cycle of
// output latency). Without it a single sample at the centre is used.

module uart_rx_fifo #(
  parameter int unsigned BIT_CYCLES = 434,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk100,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned CW   = $clog2(BIT_CYCLES);
  localparam int unsigned IW   = $clog2(DATA_BITS + 1);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PW   = AW + 1;
  localparam int unsigned WW   = DATA_BITS + 1;
  localparam int unsigned HALF = BIT_CYCLES / 2;
`ifdef UART_RX_MAJORITY_EN
  // Decision one cycle after the centre; later bits keep the same offset.
  localparam int unsigned START_TGT = HALF;
`else
  localparam int unsigned START_TGT = HALF - 1;
`endif
  localparam logic [CW-1:0] START_END = CW'(START_TGT);
  localparam logic [CW-1:0] BIT_END   = CW'(BIT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2,
    S_BREAK
  } state_t;

  // Line synchroniser; idles high so reset looks like an idle line.
  logic rx_meta;
  logic rs;
  logic smp;

`ifdef UART_RX_MAJORITY_EN
  logic rs_d1;
  logic rs_d2;

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
      rs_d1   <= 1'b1;
      rs_d2   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
      rs_d1   <= rs;
      rs_d2   <= rs_d1;
    end
  end

  // Vote over the centre sample and its two neighbours.
  assign smp = (rs_d2 & rs_d1) | (rs_d2 & rs) | (rs_d1 & rs);
`else
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rs      <= 1'b1;
    end else begin
      rx_meta <= rx;
      rs      <= rx_meta;
    end
  end

  assign smp = rs;
`endif

  // Receiver FSM state.
  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 perr, perr_n;
  logic                 push_req, push_n;
  logic                 ferr_n;
  logic [WW-1:0]        push_word;

  // Next-state logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    shreg_n = shreg;
    perr_n  = perr;
    push_n  = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rs) state_n = S_START;
      end
      S_START: begin
        if (cnt == START_END) begin
          cnt_n = '0;
          if (smp) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_DATA;
            idx_n   = '0;
            perr_n  = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          shreg_n = {smp, shreg[DATA_BITS-1:1]};
          idx_n   = idx + IW'(1);
          if (idx == LAST_IDX) state_n = (PARITY != 0) ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (cnt == BIT_END) begin
          cnt_n   = '0;
          perr_n  = ((^shreg) ^ smp) != (PARITY == 1);
          state_n = S_STOP1;
        end
      end
      S_STOP1, S_STOP2: begin
        if (cnt == BIT_END) begin
          cnt_n = '0;
          if (!smp) begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end else if ((state == S_STOP1) && (STOP_BITS == 2)) begin
            state_n = S_STOP2;
          end else begin
            // Leave at mid stop bit so a back-to-back start edge is seen.
            push_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        cnt_n = '0;
        if (rs) state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // FSM registers and pulse outputs.
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      perr      <= 1'b0;
      push_req  <= 1'b0;
      push_word <= '0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      perr      <= perr_n;
      push_req  <= push_n;
      push_word <= {perr_n, shreg_n};
      frame_err <= ferr_n;
      busy      <= (state_n != S_IDLE);
    end
  end

  // Output FIFO; pointers carry one extra wrap bit.
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr, rd, wr_n, rd_n;
  logic [WW-1:0] head, head_n;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign full    = (PW'(wr - rd) == PW'(FIFO_DEPTH));
  assign do_pop  = rx_valid & rx_ready;
  assign do_push = push_req & (~full | do_pop);
  assign wr_n    = do_push ? PW'(wr + PW'(1)) : wr;
  assign rd_n    = do_pop  ? PW'(rd + PW'(1)) : rd;

  // Next head word; bypass the write when it lands at the new read slot.
  always_comb begin
    head_n = mem[rd_n[AW-1:0]];
    if (do_push && (wr == rd_n)) head_n = push_word;
  end

  always_ff @(posedge clk100) begin
    if (do_push) mem[wr[AW-1:0]] <= push_word;
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      wr       <= '0;
      rd       <= '0;
      head     <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      wr       <= wr_n;
      rd       <= rd_n;
      head     <= head_n;
      rx_valid <= (wr_n != rd_n);
      overrun  <= push_req & full & ~do_pop;
    end
  end

  assign rx_data = head[DATA_BITS-1:0];
  assign rx_perr = head[DATA_BITS];

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_rx_fifo: two instances (8N1 and 8E2, BIT_CYCLES=16, depth 4)
// driven by frame tasks; expected words go into per-instance queues and a
// monitor pops and compares whenever a word is handed over.
module tb_uart_rx_fifo;

  localparam int unsigned BC    = 16;
  localparam int unsigned DEPTH = 4;

  logic clk100 = 1'b0;
  logic reset  = 1'b1;

  logic       rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] data_a, data_b;
  logic       perr_a, perr_b, valid_a, valid_b;
  logic       ready_a = 1'b0, ready_b = 1'b0;
  logic       fe_a, fe_b, ov_a, ov_b, busy_a, busy_b;

  logic rdy_fix_a = 1'b1, rdy_fix_b = 1'b1, rand_rdy = 1'b0;

  logic [8:0] exp_a[$];
  logic [8:0] exp_b[$];
  int n_chk = 0, n_fail = 0;
  int fe_cnt_a = 0, ov_cnt_a = 0, fe_cnt_b = 0, ov_cnt_b = 0;
  int exp_fe_a = 0, exp_ov_a = 0;

  always #5 clk100 = ~clk100;

  uart_rx_fifo #(.BIT_CYCLES(BC), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                 .FIFO_DEPTH(DEPTH)) u_a (
    .clk100(clk100), .reset(reset), .rx(rx_a), .rx_data(data_a),
    .rx_perr(perr_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .frame_err(fe_a), .overrun(ov_a), .busy(busy_a));

  uart_rx_fifo #(.BIT_CYCLES(BC), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2),
                 .FIFO_DEPTH(DEPTH)) u_b (
    .clk100(clk100), .reset(reset), .rx(rx_b), .rx_data(data_b),
    .rx_perr(perr_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .frame_err(fe_b), .overrun(ov_b), .busy(busy_b));

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: set ready for the coming edge, then check any handover on it.
  always @(negedge clk100) begin : mon
    logic [8:0] w;
    ready_a = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix_a;
    ready_b = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_fix_b;
    if (!reset) begin
      if (valid_a && ready_a) begin
        if (exp_a.size() == 0) check("a_valid_unexpected", int'(valid_a), 0);
        else begin
          w = exp_a.pop_front();
          check("a_word", int'({perr_a, data_a}), int'(w));
        end
      end
      if (valid_b && ready_b) begin
        if (exp_b.size() == 0) check("b_valid_unexpected", int'(valid_b), 0);
        else begin
          w = exp_b.pop_front();
          check("b_word", int'({perr_b, data_b}), int'(w));
        end
      end
      if (fe_a) fe_cnt_a++;
      if (ov_a) ov_cnt_a++;
      if (fe_b) fe_cnt_b++;
      if (ov_b) ov_cnt_b++;
    end
  end

  task automatic drive(input int inst, input logic b, input int n);
    if (inst == 0) rx_a = b; else rx_b = b;
    repeat (n) @(negedge clk100);
  endtask

  // One frame. Instance 0 is 8N1, instance 1 is 8E2.
  task automatic send(input int inst, input logic [7:0] d, input logic pbit,
                      input logic stop_ok);
    logic [8:0] w;
    logic       stalled;
    w = {(inst == 1) ? ((^d) ^ pbit) : 1'b0, d};
    if (!stop_ok) begin
      if (inst == 0) exp_fe_a++;
    end else if (inst == 0) begin
      stalled = !rand_rdy && !rdy_fix_a;
      if (stalled && exp_a.size() >= DEPTH) exp_ov_a++;
      else exp_a.push_back(w);
    end else begin
      exp_b.push_back(w);
    end
    drive(inst, 1'b0, BC);
    for (int i = 0; i < 8; i++) drive(inst, d[i], BC);
    if (inst == 1) drive(inst, pbit, BC);
    if (!stop_ok) drive(inst, 1'b0, BC);
    else begin
      drive(inst, 1'b1, BC);
      if (inst == 1) drive(inst, 1'b1, BC);
    end
  endtask

  task automatic wait_drain(input int inst, input int budget);
    int k;
    k = 0;
    while (((inst == 0) ? exp_a.size() : exp_b.size()) != 0 && k < budget) begin
      @(negedge clk100);
      k++;
    end
    if (inst == 0) check("a_drain_left", exp_a.size(), 0);
    else           check("b_drain_left", exp_b.size(), 0);
    repeat (4) @(negedge clk100);
    if (inst == 0) check("a_valid_after_drain", int'(valid_a), 0);
    else           check("b_valid_after_drain", int'(valid_b), 0);
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk100);
    check("rst_valid_a", int'(valid_a), 0);
    check("rst_data_a", int'(data_a), 0);
    check("rst_perr_a", int'(perr_a), 0);
    check("rst_fe_a", int'(fe_a), 0);
    check("rst_ov_a", int'(ov_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_valid_b", int'(valid_b), 0);
    check("rst_busy_b", int'(busy_b), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk100);

    // Back-to-back 8N1 frames.
    send(0, 8'hA5, 1'b0, 1'b1);
    send(0, 8'h3C, 1'b0, 1'b1);
    drive(0, 1'b1, 10);
    wait_drain(0, 200);
    check("a_fe_b2b", fe_cnt_a, exp_fe_a);

    // Short low glitch is rejected.
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 30);
    check("glitch_busy", int'(busy_a), 0);
    check("glitch_valid", int'(valid_a), 0);
    check("glitch_fe", fe_cnt_a, exp_fe_a);

    // Even parity: 0x07 has odd weight.
    send(1, 8'h07, 1'b0, 1'b1);
    send(1, 8'h07, 1'b1, 1'b1);
    drive(1, 1'b1, 10);
    wait_drain(1, 200);

    // Bad stop bit then held-low line.
    send(0, 8'h55, 1'b0, 1'b0);
    drive(0, 1'b0, 100);
    drive(0, 1'b1, 20);
    check("break_fe_count", fe_cnt_a, exp_fe_a);
    check("break_busy", int'(busy_a), 0);
    check("break_valid", int'(valid_a), 0);
    send(0, 8'h12, 1'b0, 1'b1);
    drive(0, 1'b1, 10);
    wait_drain(0, 200);

    // Overrun on a stalled consumer.
    rdy_fix_a = 1'b0;
    for (int i = 1; i <= 5; i++) send(0, 8'(i), 1'b0, 1'b1);
    drive(0, 1'b1, 30);
    check("ovr_count", ov_cnt_a, exp_ov_a);
    check("ovr_valid", int'(valid_a), 1);
    check("ovr_fe", fe_cnt_a, exp_fe_a);
    rdy_fix_a = 1'b1;
    wait_drain(0, 200);

    // Random traffic on both instances with a random consumer.
    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          send(0, 8'($urandom), 1'b0, 1'b1);
          drive(0, 1'b1, $urandom_range(0, 20));
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          send(1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
          drive(1, 1'b1, $urandom_range(0, 20));
        end
      end
    join
    drive(0, 1'b1, 10);
    rand_rdy = 1'b0;
    wait_drain(0, 300);
    wait_drain(1, 300);

    // Reset mid-frame with two words queued.
    rdy_fix_a = 1'b0;
    send(0, 8'h11, 1'b0, 1'b1);
    send(0, 8'h22, 1'b0, 1'b1);
    drive(0, 1'b1, 10);
    check("rst2_valid_before", int'(valid_a), 1);
    drive(0, 1'b0, BC);
    drive(0, 1'b1, BC);
    drive(0, 1'b0, 5);
    reset = 1'b1;
    #1;
    check("rst2_valid", int'(valid_a), 0);
    check("rst2_busy", int'(busy_a), 0);
    exp_a.delete();
    rx_a = 1'b1;
    repeat (3) @(negedge clk100);
    reset = 1'b0;
    rdy_fix_a = 1'b1;
    repeat (5) @(negedge clk100);
    send(0, 8'h81, 1'b0, 1'b1);
    drive(0, 1'b1, 10);
    wait_drain(0, 200);

    check("a_ov_final", ov_cnt_a, exp_ov_a);
    check("a_fe_final", fe_cnt_a, exp_fe_a);
    check("b_fe_final", fe_cnt_b, 0);
    check("b_ov_final", ov_cnt_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
